seq_frame_tx: RTL

SEQ_FRAME_TX -- requirements
Module: seq_frame_tx

---
 rtl/seq_frame_pkg.sv | 32 +++
 rtl/seq_frame_shifter.sv | 43 ++++
 rtl/seq_frame_tx.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/seq_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_frame_pkg
// Purpose  : Shared constants for the serial frame transmitter: FSM state
//            encoding, preamble length and default pattern, length-field
//            width, and a helper that picks one preamble bit MSB-first.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package seq_frame_pkg;

    // Preamble length in bits and its default pattern (sent MSB-first).
    localparam int unsigned SYNC_LEN         = 4;
    localparam logic [3:0]  SYNC_PAT_DEFAULT = 4'b1010;

    // Width of the payload length field (length minus one).
    localparam int unsigned LEN_W = 4;

    // FSM state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    // Preamble bit number idx (0 = first on the wire = pattern MSB).
    function automatic logic sync_bit(input logic [SYNC_LEN-1:0] pat,
                                      input logic [1:0]          idx);
        return pat[2'd3 - idx];
    endfunction

endpackage : seq_frame_pkg
`default_nettype wire

// File: rtl/seq_frame_shifter.sv
`default_nettype none
// ============================================================================
// Module   : seq_frame_shifter
// Purpose  : Payload holding register for the frame transmitter. Loads a
//            pre-aligned word, shifts left one place per request and exposes
//            its MSB as the next serial bit.
// Ports    : clk        - clock, rising edge
//            rst        - synchronous active-high reset, clears the word
//            load       - load load_value (has priority over shift)
//            load_value - aligned payload word, first bit in the MSB
//            shift      - shift the word left by one, filling with zero
//            msb        - current most significant bit of the word
// Revision : 1.0 - initial release
// ============================================================================
module seq_frame_shifter
    import seq_frame_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_value,
    input  logic              shift,
    output logic              msb
);

    logic [DATA_W-1:0] r_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word <= '0;
        end else if (load) begin
            r_word <= load_value;
        end else if (shift) begin
            r_word <= r_word << 1;
        end
    end

    assign msb = r_word[DATA_W-1];

endmodule : seq_frame_shifter
`default_nettype wire

// File: rtl/seq_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : seq_frame_tx
// Purpose  : Serial frame transmitter. After a valid/ready handshake it sends
//            a 4-bit preamble, then the low N payload bits MSB-first, then
//            GAP_CYCLES idle-low cycles, and returns to IDLE. All outputs are
//            registered and reflect the state being occupied in that cycle.
// Ports    : clk        - clock, rising edge
//            rst        - synchronous active-high reset, aborts any frame
//            load_valid - load_data/load_len valid this cycle
//            load_ready - frame can be accepted this cycle (IDLE only)
//            load_data  - payload word
//            load_len   - payload length minus one (N = load_len + 1)
//            data_out   - serial bit stream
//            bit_valid  - data_out carries a preamble or payload bit
//            busy       - high in SYNC, DATA and GAP
//            frame_done - pulse on the cycle carrying payload bit 0
// Revision : 1.0 - initial release
// ============================================================================
module seq_frame_tx
    import seq_frame_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,   // must be at least 16
    parameter int unsigned GAP_CYCLES = 2,    // 1..15
    parameter logic [3:0]  SYNC_PAT   = SYNC_PAT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic [LEN_W-1:0]  load_len,
    output logic              data_out,
    output logic              bit_valid,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [3:0] c_gap_last  = 4'(GAP_CYCLES - 1);
    localparam logic [1:0] c_sync_last = 2'(SYNC_LEN - 1);

    logic [1:0]        r_state;
    logic [1:0]        r_sync_cnt;
    logic [3:0]        r_bit_cnt;
    logic [3:0]        r_gap_cnt;

    logic [1:0]        w_state_nxt;
    logic [1:0]        w_sync_cnt_nxt;
    logic [3:0]        w_bit_cnt_nxt;
    logic [3:0]        w_gap_cnt_nxt;
    logic              w_data_out_nxt;
    logic              w_bit_valid_nxt;
    logic              w_frame_done_nxt;

    logic              w_accept;
    logic              w_load;
    logic              w_shift;
    logic              w_msb;
    logic [31:0]       w_shamt;
    logic [DATA_W-1:0] w_aligned;

    // load_ready is itself a register that is high only in IDLE, so the
    // handshake never depends combinationally on anything but load_valid.
    assign w_accept = load_valid & load_ready;

    // Left-justify the low N payload bits so the shifter's MSB is
    // load_data[N-1]; bits above N-1 fall off the top.
    assign w_shamt   = 32'(DATA_W) - 32'd1 - {28'd0, load_len};
    assign w_aligned = load_data << w_shamt;

    seq_frame_shifter #(
        .DATA_W (DATA_W)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .load       (w_load),
        .load_value (w_aligned),
        .shift      (w_shift),
        .msb        (w_msb)
    );

    // Next-state logic. The output values computed here are those of the
    // state being entered, so the registered outputs line up with r_state.
    always_comb begin
        w_state_nxt      = r_state;
        w_sync_cnt_nxt   = r_sync_cnt;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_gap_cnt_nxt    = r_gap_cnt;
        w_load           = 1'b0;
        w_shift          = 1'b0;
        w_data_out_nxt   = 1'b0;
        w_bit_valid_nxt  = 1'b0;
        w_frame_done_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt     = ST_SYNC;
                    w_sync_cnt_nxt  = 2'd0;
                    w_bit_cnt_nxt   = load_len;
                    w_load          = 1'b1;
                    w_data_out_nxt  = sync_bit(SYNC_PAT, 2'd0);
                    w_bit_valid_nxt = 1'b1;
                end
            end

            ST_SYNC: begin
                w_bit_valid_nxt = 1'b1;
                if (r_sync_cnt == c_sync_last) begin
                    // First payload bit; for N = 1 it is also the last.
                    w_state_nxt      = ST_DATA;
                    w_data_out_nxt   = w_msb;
                    w_shift          = 1'b1;
                    w_frame_done_nxt = (r_bit_cnt == 4'd0);
                end else begin
                    w_sync_cnt_nxt = r_sync_cnt + 2'd1;
                    w_data_out_nxt = sync_bit(SYNC_PAT, r_sync_cnt + 2'd1);
                end
            end

            ST_DATA: begin
                // r_bit_cnt is the index of the bit on the wire this cycle.
                if (r_bit_cnt == 4'd0) begin
                    w_state_nxt   = ST_GAP;
                    w_gap_cnt_nxt = c_gap_last;
                end else begin
                    w_bit_cnt_nxt    = r_bit_cnt - 4'd1;
                    w_data_out_nxt   = w_msb;
                    w_shift          = 1'b1;
                    w_bit_valid_nxt  = 1'b1;
                    w_frame_done_nxt = (r_bit_cnt == 4'd1);
                end
            end

            ST_GAP: begin
                if (r_gap_cnt == 4'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 4'd1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_sync_cnt <= 2'd0;
            r_bit_cnt  <= 4'd0;
            r_gap_cnt  <= 4'd0;
            data_out   <= 1'b0;
            bit_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_sync_cnt <= w_sync_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            data_out   <= w_data_out_nxt;
            bit_valid  <= w_bit_valid_nxt;
            busy       <= (w_state_nxt != ST_IDLE);
            frame_done <= w_frame_done_nxt;
            load_ready <= (w_state_nxt == ST_IDLE);
        end
    end

endmodule : seq_frame_tx
`default_nettype wire
